fle_ccff_loader: RTL and testbench

FLE_CCFF_LOADER -- requirements
Module: fle_ccff_loader

---
 rtl/fle_ccff_loader.sv | 179 +++++++++++++++++
 tb/tb_fle_ccff_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fle_ccff_loader.sv
// ============================================================================
// fle_ccff_loader : streams a bitstream into a ccff chain, packs the old chain
// contents into readback words. Revision 1.0
// ============================================================================
`default_nettype none

module fle_ccff_loader #(
  parameter int CHAIN_LEN = 80,
  parameter int WORD_W    = 32
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              busy,
  output logic              done
);

  localparam int NW     = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int BC_W   = $clog2(CHAIN_LEN + 1);
  localparam int CNT_W  = $clog2(WORD_W + 1);
  localparam int NW_W   = $clog2(NW + 1);

  localparam logic [NW_W-1:0]  NW_V      = NW_W'(NW);
  localparam logic [NW_W-1:0]  NW_LAST   = NW_W'(NW - 1);
  localparam logic [BC_W-1:0]  BC_LAST   = BC_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_BITS = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] PK_LAST   = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LAST_BITS = CNT_W'(CHAIN_LEN - (NW - 1) * WORD_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q,   state_d;
  logic [WORD_W-1:0]  buf_q,     buf_d;
  logic [CNT_W-1:0]   buf_cnt_q, buf_cnt_d;
  logic [NW_W-1:0]    words_q,   words_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]  pk_q,      pk_d;
  logic [CNT_W-1:0]   pk_cnt_q,  pk_cnt_d;
  logic [WORD_W-1:0]  rb_data_q, rb_data_d;
  logic               rb_valid_q, rb_valid_d;

  logic              shift;
  logic              rb_take;
  logic              in_load;
  logic [WORD_W-1:0] pk_new;

  assign in_load = (state_q == SHIFT) || (state_q == FLUSH);
  assign s_ready = (state_q == SHIFT) && (buf_cnt_q == '0) && (words_q != NW_V);
  // A pending, unaccepted readback word blocks shifting so no tail bit is dropped.
  assign shift   = (state_q == SHIFT) && (buf_cnt_q != '0) &&
                   !(rb_valid_q && !rb_ready) && !abort;
  assign rb_take = rb_valid_q && rb_ready;
  assign pk_new  = pk_q | (WORD_W'(ccff_tail) << pk_cnt_q);

  assign ccff_shift_en = shift;
  assign ccff_head     = shift & buf_q[0];
  assign rb_data       = rb_data_q;
  assign rb_valid      = rb_valid_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_cnt_d  = buf_cnt_q;
    words_d    = words_q;
    bit_cnt_d  = bit_cnt_q;
    pk_d       = pk_q;
    pk_cnt_d   = pk_cnt_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = rb_valid_q;

    if (rb_take) begin
      rb_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          buf_d     = '0;
          buf_cnt_d = '0;
          words_d   = '0;
          bit_cnt_d = '0;
          pk_d      = '0;
          pk_cnt_d  = '0;
        end
      end
      SHIFT: begin
        if (s_valid && s_ready) begin
          buf_d     = s_data;
          buf_cnt_d = (words_q == NW_LAST) ? LAST_BITS : FULL_BITS;
          words_d   = words_q + 1'b1;
        end
        if (shift) begin
          buf_d     = buf_q >> 1;
          buf_cnt_d = buf_cnt_q - 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          pk_d      = pk_new;
          pk_cnt_d  = pk_cnt_q + 1'b1;
          if ((bit_cnt_q == BC_LAST) || (pk_cnt_q == PK_LAST)) begin
            rb_data_d  = pk_new;
            rb_valid_d = 1'b1;
            pk_d       = '0;
            pk_cnt_d   = '0;
          end
          if (bit_cnt_q == BC_LAST) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (rb_take) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && in_load) begin
      state_d    = IDLE;
      buf_d      = '0;
      buf_cnt_d  = '0;
      words_d    = '0;
      bit_cnt_d  = '0;
      pk_d       = '0;
      pk_cnt_d   = '0;
      rb_data_d  = '0;
      rb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_cnt_q  <= '0;
      words_q    <= '0;
      bit_cnt_q  <= '0;
      pk_q       <= '0;
      pk_cnt_q   <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_cnt_q  <= buf_cnt_d;
      words_q    <= words_d;
      bit_cnt_q  <= bit_cnt_d;
      pk_q       <= pk_d;
      pk_cnt_q   <= pk_cnt_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fle_ccff_loader.sv
// ============================================================================
// tb_fle_ccff_loader : directed, table-driven bench with a ccff chain model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fle_ccff_loader;

  localparam int CL = 80;
  localparam int WW = 32;

  logic          prog_clk = 1'b0;
  logic          pReset_n;
  logic          start, abort, s_valid, s_ready;
  logic          ccff_head, ccff_shift_en, ccff_tail;
  logic          rb_valid, rb_ready, busy, done;
  logic [WW-1:0] s_data, rb_data;

  logic [CL-1:0] chain = '0;
  logic [CL-1:0] chain_pre = '0;
  logic          load_chain = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            keep;
    logic [CL-1:0] pre;
    logic [WW-1:0] w0, w1, w2;
    int            gap;
    int            bp;
    int            restart;
    bit            abort_start;
    logic [WW-1:0] r0, r1, r2;
    int            lat;
  } vec_t;

  vec_t tbl[5];

  always #5 prog_clk = ~prog_clk;

  assign ccff_tail = chain[CL-1];

  always @(posedge prog_clk) begin
    if (load_chain) chain <= chain_pre;
    else if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
  end

  fle_ccff_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk      (prog_clk),
    .pReset_n      (pReset_n),
    .start         (start),
    .abort         (abort),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .rb_data       (rb_data),
    .rb_valid      (rb_valid),
    .rb_ready      (rb_ready),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // First bit written ends up at the chain tail end (index CL-1).
  function automatic logic [CL-1:0] exp_chain(input logic [WW-1:0] w0, w1, w2);
    logic [CL-1:0] s;
    logic [CL-1:0] r;
    s = {w2[15:0], w1, w0};
    for (int i = 0; i < CL; i++) r[CL-1-i] = s[i];
    return r;
  endfunction

  function automatic vec_t mk(input bit keep, input logic [CL-1:0] pre,
                              input logic [WW-1:0] w0, w1, w2,
                              input int gap, bp, restart, input bit ab,
                              input logic [WW-1:0] r0, r1, r2, input int lat);
    vec_t v;
    v.keep = keep; v.pre = pre; v.w0 = w0; v.w1 = w1; v.w2 = w2;
    v.gap = gap; v.bp = bp; v.restart = restart; v.abort_start = ab;
    v.r0 = r0; v.r1 = r1; v.r2 = r2; v.lat = lat;
    return v;
  endfunction

  // Caller must be aligned just after a falling edge.
  task automatic run_load(input vec_t v, input string tag);
    logic [WW-1:0] words[3];
    logic [WW-1:0] exp_rb[3];
    logic [WW-1:0] got[3];
    int  wi, nrb, nshift, ndone, lat, gap_left, bp_left, viol;
    bit  gap_armed, bp_armed;
    words[0] = v.w0; words[1] = v.w1; words[2] = v.w2;
    exp_rb[0] = v.r0; exp_rb[1] = v.r1; exp_rb[2] = v.r2;
    got[0] = '0; got[1] = '0; got[2] = '0;
    wi = 0; nrb = 0; nshift = 0; ndone = 0; lat = -1;
    gap_left = 0; bp_left = 0; viol = 0; gap_armed = 0; bp_armed = 0;
    chain_pre = v.pre;
    for (int cyc = 0; cyc < 400; cyc++) begin
      start      = (cyc == 0) || (v.restart != 0 && cyc == v.restart);
      abort      = (cyc == 0) && v.abort_start;
      load_chain = (cyc == 0) && !v.keep;
      #1;
      if (!gap_armed && v.gap > 0 && wi == 2 && s_ready) begin
        gap_armed = 1; gap_left = v.gap;
      end
      s_valid = (wi < 3) && (gap_left == 0);
      s_data  = (wi < 3) ? words[wi] : '0;
      if (!bp_armed && rb_valid) begin
        bp_armed = 1; bp_left = v.bp;
      end
      rb_ready = (bp_left == 0);
      #1;
      if ((gap_left > 0 || bp_left > 0) && ccff_shift_en) viol++;
      if (bp_left > 0 && rb_data !== v.r0) viol++;
      if (s_valid && s_ready) wi++;
      if (rb_valid && rb_ready) begin
        if (nrb < 3) got[nrb] = rb_data;
        nrb++;
      end
      if (ccff_shift_en) nshift++;
      if (done) begin
        ndone++;
        if (lat < 0) lat = cyc;
      end
      if (gap_left > 0) gap_left--;
      if (bp_left > 0) bp_left--;
      if (lat >= 0 && cyc >= lat + 3) break;
      @(negedge prog_clk);
    end
    start = 0; abort = 0; s_valid = 0; rb_ready = 1; load_chain = 0;
    chk({tag, " latency"},    lat,    v.lat);
    chk({tag, " done_count"}, ndone,  1);
    chk({tag, " shifts"},     nshift, CL);
    chk({tag, " rb_count"},   nrb,    3);
    for (int k = 0; k < 3; k++) chk($sformatf("%s rb%0d", tag, k), got[k], exp_rb[k]);
    chk({tag, " stall_viol"}, viol,   0);
    chk({tag, " busy_end"},   busy,   1'b0);
    @(negedge prog_clk);
    chk({tag, " chain"},      chain,  exp_chain(v.w0, v.w1, v.w2));
  endtask

  initial begin
    int nshift, ndone;
    pReset_n = 0; start = 0; abort = 0; s_valid = 0; s_data = '0; rb_ready = 1;

    tbl[0] = mk(0, '1, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0000BEEF, 0, 0, 10, 0,
                32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 85);
    tbl[1] = mk(1, '0, 32'h12345678, 32'h9ABCDEF0, 32'hFFFF5A5A, 0, 0, 0, 0,
                32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0000BEEF, 85);
    tbl[2] = mk(0, '0, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0000BEEF, 5, 0, 0, 0,
                32'h0, 32'h0, 32'h0, 90);
    tbl[3] = mk(0, '1, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0000BEEF, 0, 10, 0, 0,
                32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 94);
    tbl[4] = mk(0, '1, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0000BEEF, 0, 0, 0, 1,
                32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 85);

    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    chk("rst s_ready",  s_ready,       1'b0);
    chk("rst shift_en", ccff_shift_en, 1'b0);
    chk("rst head",     ccff_head,     1'b0);
    chk("rst rb_data",  rb_data,       32'h0);
    chk("rst rb_valid", rb_valid,      1'b0);
    chk("rst busy",     busy,          1'b0);
    chk("rst done",     done,          1'b0);

    pReset_n = 1;
    for (int i = 0; i < 4; i++) run_load(tbl[i], $sformatf("vec%0d", i));

    // Abort after 40 shifts, then a full load must still work.
    chain_pre = '1; load_chain = 1; start = 1; s_valid = 1; s_data = 32'hA5A5A5A5; rb_ready = 1;
    nshift = 0;
    for (int c = 0; c < 200 && nshift < 40; c++) begin
      #2;
      if (ccff_shift_en) nshift++;
      @(negedge prog_clk);
      start = 0; load_chain = 0;
    end
    chk("abort shifts_before", nshift, 40);
    abort = 1;
    #2;
    chk("abort no_shift", ccff_shift_en, 1'b0);
    @(negedge prog_clk);
    abort = 0;
    #2;
    chk("abort busy",     busy,     1'b0);
    chk("abort rb_valid", rb_valid, 1'b0);
    chk("abort s_ready",  s_ready,  1'b0);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) ndone++;
      @(negedge prog_clk);
      #2;
    end
    chk("abort no_done", ndone, 0);
    s_valid = 0;
    @(negedge prog_clk);
    run_load(tbl[0], "post_abort");

    // Reset in the middle of a load.
    chain_pre = '1; load_chain = 1; start = 1; s_valid = 1; s_data = 32'hA5A5A5A5; rb_ready = 1;
    for (int c = 0; c < 36; c++) begin
      @(negedge prog_clk);
      start = 0; load_chain = 0;
    end
    @(posedge prog_clk);
    #3;
    pReset_n = 0;
    #1;
    chk("midrst outputs", {s_ready, ccff_head, ccff_shift_en, rb_valid, busy, done}, 6'b0);
    chk("midrst rb_data", rb_data, 32'h0);
    nshift = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge prog_clk);
      start = c[0];
      #2;
      if (ccff_shift_en) nshift++;
    end
    chk("midrst shifts", nshift, 0);
    start = 0; s_valid = 0;
    @(negedge prog_clk);
    pReset_n = 1;
    run_load(tbl[4], "start_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
